// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: latched cabin/hall calls, SCAN scheduling, timed travel and door dwell.
// Optional feature: define DOOR_HOLD_EN to make door_hold and calls at the open floor restart the dwell.
module elevator_ctrl_n #(
    parameter int N_FLOORS   = 4,
    parameter int FW         = $clog2(N_FLOORS),
    parameter int TRAVEL_CYC = 200000000,
    parameter int DOOR_CYC   = 200000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] car_req,
    input  logic [N_FLOORS-1:0] hall_up,
    input  logic [N_FLOORS-1:0] hall_dn,
    input  logic                door_hold,
    output logic [FW-1:0]       floor,
    output logic [1:0]          motion,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending
);
    localparam int T_MAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] TRAVEL_TC = TW'(TRAVEL_CYC - 1);
    localparam logic [TW-1:0] DOOR_TC   = TW'(DOOR_CYC - 1);
    localparam logic [N_FLOORS-1:0] TOP_BIT = N_FLOORS'(1) << (N_FLOORS - 1);
    localparam logic [N_FLOORS-1:0] BOT_BIT = N_FLOORS'(1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    state_t              state, state_n;
    logic                dir_up, dir_n;
    logic [FW-1:0]       floor_n, nf;
    logic [TW-1:0]       timer, timer_n;
    logic [N_FLOORS-1:0] req_car, req_up, req_dn, all_req;
    logic [N_FLOORS-1:0] clr_car, clr_up, clr_dn;
    logic [N_FLOORS-1:0] up_in, dn_in, door_mask, here, here_nf;
    logic [N_FLOORS-1:0] above_m, below_m, beyond_m;
    logic                above, below, further, hall_dir, at_end;

    // Unserviceable hall directions at the end floors are dropped at the input.
    assign up_in     = hall_up & ~TOP_BIT;
    assign dn_in     = hall_dn & ~BOT_BIT;
    assign all_req   = req_car | req_up | req_dn;
    assign here      = N_FLOORS'(1) << floor;
    assign door_mask = (state == S_DOOR) ? here : '0;
    assign motion    = (state == S_MOVE) ? (dir_up ? 2'd1 : 2'd2) : 2'd0;
    assign door_open = (state == S_DOOR);

`ifndef DOOR_HOLD_EN
    logic unused_hold;
    assign unused_hold = door_hold;
`endif

    always_comb begin
        state_n  = state;
        floor_n  = floor;
        dir_n    = dir_up;
        timer_n  = timer;
        clr_car  = '0;
        clr_up   = '0;
        clr_dn   = '0;
        further  = 1'b0;
        hall_dir = 1'b0;
        nf       = dir_up ? floor + 1'b1 : floor - 1'b1;
        here_nf  = N_FLOORS'(1) << nf;
        at_end   = dir_up ? (int'(floor) == N_FLOORS - 1) : (floor == '0);
        for (int i = 0; i < N_FLOORS; i++) begin
            above_m[i]  = (i > int'(floor));
            below_m[i]  = (i < int'(floor));
            beyond_m[i] = dir_up ? (i > int'(nf)) : (i < int'(nf));
        end
        above = |(all_req & above_m);
        below = |(all_req & below_m);

        case (state)
            S_IDLE: begin
                if (|(all_req & here)) begin
                    state_n = S_DOOR;
                    timer_n = '0;
                    clr_car = here;
                    if (dir_up) begin
                        clr_up = here;
                        if (!req_up[floor]) clr_dn = here;
                    end else begin
                        clr_dn = here;
                        if (!req_dn[floor]) clr_up = here;
                    end
                end else if (above && (dir_up || !below)) begin
                    state_n = S_MOVE;
                    dir_n   = 1'b1;
                    timer_n = '0;
                end else if (below) begin
                    state_n = S_MOVE;
                    dir_n   = 1'b0;
                    timer_n = '0;
                end
            end
            S_MOVE: begin
                if (timer != TRAVEL_TC) begin
                    timer_n = timer + 1'b1;
                end else if (at_end) begin
                    state_n = S_IDLE;
                    dir_n   = !dir_up;
                    timer_n = '0;
                end else begin
                    floor_n  = nf;
                    timer_n  = '0;
                    further  = |(all_req & beyond_m);
                    hall_dir = dir_up ? req_up[nf] : req_dn[nf];
                    if (req_car[nf] || hall_dir || !further) begin
                        state_n = S_DOOR;
                        clr_car = here_nf;
                        if (dir_up) clr_up = here_nf;
                        else        clr_dn = here_nf;
                        if (!further) begin
                            clr_up = here_nf;
                            clr_dn = here_nf;
                        end
                    end
                end
            end
            S_DOOR: begin
`ifdef DOOR_HOLD_EN
                if (door_hold || |((car_req | up_in | dn_in) & here)) begin
                    timer_n = '0;
                end else
`endif
                if (timer == DOOR_TC) begin
                    state_n = S_IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            floor   <= '0;
            dir_up  <= 1'b1;
            timer   <= '0;
            req_car <= '0;
            req_up  <= '0;
            req_dn  <= '0;
            pending <= '0;
        end else begin
            state   <= state_n;
            floor   <= floor_n;
            dir_up  <= dir_n;
            timer   <= timer_n;
            // Calls at the floor whose doors are open are absorbed, not latched.
            req_car <= (req_car & ~clr_car) | (car_req & ~door_mask);
            req_up  <= (req_up & ~clr_up) | (up_in & ~door_mask);
            req_dn  <= (req_dn & ~clr_dn) | (dn_in & ~door_mask);
            pending <= all_req;
        end
    end
endmodule
